// File: rtl/sort_unload.sv
// Sorted-vector unload stage: holds one sorted vector and streams it out one element per beat.
// Define SORT_UNLOAD_DESC_EN to stream in descending order (largest element first).
module sort_unload #(
    parameter int unsigned Width      = 8,
    parameter int unsigned Index      = 8,
    parameter int unsigned IndexWidth = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [0:Index-1][Width-1:0]       in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [Width-1:0]                  out_data,
    output logic [IndexWidth-1:0]             out_index,
    output logic                              out_last,
    output logic [15:0]                       vec_count
);

`ifdef SORT_UNLOAD_DESC_EN
    localparam logic [IndexWidth-1:0] FirstPos = IndexWidth'(Index - 1);
    localparam logic [IndexWidth-1:0] LastPos  = '0;
    localparam logic [IndexWidth-1:0] Step     = '1;
`else
    localparam logic [IndexWidth-1:0] FirstPos = '0;
    localparam logic [IndexWidth-1:0] LastPos  = IndexWidth'(Index - 1);
    localparam logic [IndexWidth-1:0] Step     = IndexWidth'(1);
`endif

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                  state_q, state_d;
    logic [Width-1:0]        hold_q [Index];
    logic [Width-1:0]        hold_d [Index];
    logic                    out_valid_q, out_valid_d;
    logic [Width-1:0]        out_data_q, out_data_d;
    logic [IndexWidth-1:0]   out_index_q, out_index_d;
    logic                    out_last_q, out_last_d;
    logic [15:0]             vec_count_q, vec_count_d;

    logic                    beat;
    logic                    capture;
    logic [IndexWidth-1:0]   next_pos;

    assign beat      = out_valid_q && out_ready;
    // A new vector may enter only when the buffer is empty or its final element leaves now.
    assign in_ready  = !rst && ((state_q == StIdle) || (beat && out_last_q));
    assign capture   = in_valid && in_ready;
    assign next_pos  = out_index_q + Step;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        vec_count_d = vec_count_q;

        if (beat) begin
            if (out_last_q) begin
                vec_count_d = vec_count_q + 16'd1;
                state_d     = StIdle;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                out_index_d = next_pos;
                out_data_d  = hold_q[next_pos];
                out_last_d  = (next_pos == LastPos);
            end
        end

        // Capture overrides the end-of-vector transition so a back-to-back vector has no bubble.
        if (capture) begin
            for (int i = 0; i < Index; i++) begin
                hold_d[i] = in_data[i];
            end
            state_d     = StStream;
            out_valid_d = 1'b1;
            out_index_d = FirstPos;
            out_data_d  = in_data[FirstPos];
            out_last_d  = (FirstPos == LastPos);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            for (int i = 0; i < Index; i++) begin
                hold_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            vec_count_q <= vec_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_sort_unload.sv
// Bench for sort_unload: queue-based expected-stream model checked every cycle, plus literal checks.
module tb_sort_unload;
    localparam int unsigned Width      = 8;
    localparam int unsigned Index      = 8;
    localparam int unsigned IndexWidth = 3;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         in_valid;
    logic                         in_ready;
    logic [0:Index-1][Width-1:0]  in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [Width-1:0]             out_data;
    logic [IndexWidth-1:0]        out_index;
    logic                         out_last;
    logic [15:0]                  vec_count;

    sort_unload #(
        .Width      (Width),
        .Index      (Index),
        .IndexWidth (IndexWidth)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .vec_count  (vec_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stream of elements still owed downstream, plus the completed-vector count.
    typedef struct {
        logic [Width-1:0] d;
        int               idx;
        bit               last;
    } elem_t;

    elem_t       exp_q[$];
    logic [15:0] model_vc = '0;
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        bit rdy;
        elem_t e;
        if (rst) begin
            exp_q.delete();
            model_vc = '0;
            model_on = 1'b1;
        end else if (model_on) begin
            rdy = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
            if (exp_q.size() > 0 && out_ready) begin
                if (exp_q[0].last) model_vc = model_vc + 16'd1;
                void'(exp_q.pop_front());
            end
            if (in_valid && rdy) begin
                for (int k = 0; k < Index; k++) begin
`ifdef SORT_UNLOAD_DESC_EN
                    e.idx  = Index - 1 - k;
`else
                    e.idx  = k;
`endif
                    e.d    = in_data[e.idx];
                    e.last = (k == Index - 1);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Per-cycle comparison at the inactive edge; also logs accepted beats for literal checks.
    logic [Width-1:0] seen[$];
    int               seen_cyc[$];
    int               cyc = 0;

    always @(negedge clk) begin
        bit exp_rdy;
        cyc++;
        if (model_on) begin
            exp_rdy = !rst && ((exp_q.size() == 0) || (out_ready && exp_q.size() == 1));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("vec_count", 32'(vec_count), 32'(model_vc));
            if (exp_q.size() > 0) begin
                check("out_data", 32'(out_data), 32'(exp_q[0].d));
                check("out_index", 32'(out_index), 32'(exp_q[0].idx));
                check("out_last", 32'(out_last), 32'(exp_q[0].last));
            end
        end
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            seen.push_back(out_data);
            seen_cyc.push_back(cyc);
        end
    end

    function automatic logic [Width-1:0] lit_elem(input int base, input int k);
`ifdef SORT_UNLOAD_DESC_EN
        return Width'(base + Index - 1 - k);
`else
        return Width'(base + k);
`endif
    endfunction

    task automatic check_seen(input string name, input int base, input int off);
        for (int k = 0; k < Index; k++) begin
            if (off + k < seen.size()) check(name, 32'(seen[off + k]), 32'(lit_elem(base, k)));
            else check({name, "_missing"}, 32'(k), 32'(Index));
        end
    endtask

    task automatic set_vec(input int base);
        for (int k = 0; k < Index; k++) in_data[k] = Width'(base + k);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit got;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_vec(0);

        // Reset then idle
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_vec_count", 32'(vec_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single vector, free-flowing output
        tick();
        out_ready = 1'b1;
        set_vec(1);
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        repeat (10) tick();
        check("single_count", 32'(seen.size()), 32'(Index));
        check_seen("single_seq", 1, 0);
        check("single_vc", 32'(vec_count), 32'd1);
        check("single_idle", 32'(out_valid), 32'd0);
        seen.delete();
        seen_cyc.delete();

        // Back-pressure with ready pattern 1,0,0,1
        set_vec(1);
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            in_valid  = 1'b0;
            out_ready = (k % 4 == 0) || (k % 4 == 3);
        end
        check("bp_count", 32'(seen.size()), 32'(Index));
        check_seen("bp_seq", 1, 0);
        check("bp_vc", 32'(vec_count), 32'd2);
        seen.delete();
        seen_cyc.delete();

        // Back-to-back: B waits on the input until A's last beat
        out_ready = 1'b1;
        tick();
        set_vec(0);
        in_valid = 1'b1;
        tick();
        set_vec(10);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check("b2b_capture", 32'(got), 32'd1);
        tick();
        in_valid = 1'b0;
        repeat (12) tick();
        check("b2b_count", 32'(seen.size()), 32'(2 * Index));
        check_seen("b2b_seq_a", 0, 0);
        check_seen("b2b_seq_b", 10, Index);
        if (seen_cyc.size() == 2 * Index)
            check("b2b_nogap", 32'(seen_cyc[2*Index-1] - seen_cyc[0]), 32'(2 * Index - 1));
        check("b2b_vc", 32'(vec_count), 32'd4);
        seen.delete();
        seen_cyc.delete();

        // Reset mid-stream after three beats
        set_vec(1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_vc", 32'(vec_count), 32'd0);
        check("mid_rst_beats", 32'(seen.size()), 32'd3);
        for (int k = 0; k < 3 && k < seen.size(); k++)
            check("mid_rst_seq", 32'(seen[k]), 32'(lit_elem(1, k)));
        seen.delete();
        seen_cyc.delete();
        tick();
        set_vec(9);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check_seen("post_rst_seq", 9, 0);
        check("post_rst_vc", 32'(vec_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
